mem_port_arbiter: RTL and testbench

- Sequences a single-port, variable-latency unified memory between two requesters: instruction fetch (I-port) and the pipeline memory stage (D-port).
- The memory stage supplies the address, write data and load/store control. This block owns the memory handshake, generates byte strobes, and returns read data and stall signals to the pipeline.
- Only one transaction is outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/store_align.sv | 39 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // One-hot byte lane for a byte access at the given word offset.
    function automatic logic [3:0] byte_lane(input logic [1:0] addr_lo);
        logic [3:0] lane;
        lane = 4'b0001 << addr_lo;
        return lane;
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte strobes, replicated write data
// and the misalignment / illegal-size flag for a D-port access.
module store_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_aligned,
    output logic        misaligned
);

    always_comb begin
        wstrb         = 4'b0000;
        wdata_aligned = wdata;
        misaligned    = 1'b0;
        case (size)
            SZ_B: begin
                wstrb         = byte_lane(addr_lo);
                wdata_aligned = {4{wdata[7:0]}};
            end
            SZ_H: begin
                wstrb         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                misaligned    = addr_lo[0];
            end
            SZ_W: begin
                wstrb         = 4'b1111;
                wdata_aligned = wdata;
                misaligned    = (addr_lo != 2'b00);
            end
            default: begin
                misaligned    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between I-fetch and D-memory ports onto one
// variable-latency memory. Optional round-robin: define MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_err,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]        state_reg;
    owner_e            owner_reg;
    logic              err_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [3:0]        mem_wstrb_reg;

    logic [3:0]        d_wstrb;
    logic [31:0]       d_wdata_aligned;
    logic              d_misaligned;

    store_align u_store_align (
        .size          (d_size),
        .addr_lo       (d_addr[1:0]),
        .wdata         (d_wdata),
        .wstrb         (d_wstrb),
        .wdata_aligned (d_wdata_aligned),
        .misaligned    (d_misaligned)
    );

    logic can_start;
    logic prio_d;
    logic d_wins;
    logic start_err;
    logic start_d;
    logic start_i;

`ifdef MEM_ARB_RR_EN
    owner_e last_owner_reg;

    // The requester not served last wins a tie; a faulty D access never waits.
    assign prio_d = (last_owner_reg == OWN_I);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_reg <= OWN_I;
        end else if (start_d) begin
            last_owner_reg <= OWN_D;
        end else if (start_i) begin
            last_owner_reg <= OWN_I;
        end
    end
`else
    assign prio_d = 1'b1;
`endif

    // While an error pulse is in flight the D request is still held, so a
    // new start is blocked for that cycle to avoid reissuing it.
    assign can_start = (state_reg == S_IDLE) && !err_reg;
    assign d_wins    = d_req && (d_misaligned || !i_req || prio_d);
    assign start_err = can_start && d_wins && d_misaligned;
    assign start_d   = can_start && d_wins && !d_misaligned;
    assign start_i   = can_start && i_req && !d_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            owner_reg     <= OWN_I;
            err_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= 4'b0000;
        end else begin
            err_reg <= start_err;
            case (state_reg)
                S_IDLE: begin
                    if (start_d) begin
                        owner_reg     <= OWN_D;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= d_we;
                        mem_addr_reg  <= d_addr & ~ADDR_W'(3);
                        mem_wdata_reg <= d_wdata_aligned;
                        mem_wstrb_reg <= d_we ? d_wstrb : 4'b0000;
                        state_reg     <= S_REQ;
                    end else if (start_i) begin
                        owner_reg     <= OWN_I;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= i_addr & ~ADDR_W'(3);
                        mem_wdata_reg <= '0;
                        mem_wstrb_reg <= 4'b0000;
                        state_reg     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg   <= S_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    logic resp_done;
    assign resp_done = (state_reg == S_RESP) && mem_rvalid;

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign i_rvalid = resp_done && (owner_reg == OWN_I);
    assign d_rvalid = (resp_done && (owner_reg == OWN_D)) || err_reg;
    assign d_err    = err_reg;
    assign i_stall  = i_req && !i_rvalid;
    assign d_stall  = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build, fixed D priority).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_err;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_rvalid   (i_rvalid),
        .i_stall    (i_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_rvalid   (d_rvalid),
        .d_err      (d_err),
        .d_stall    (d_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Store with immediate grant and one-cycle response latency.
    task automatic store_imm(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ew);
        tick;
        d_req = 1'b1; d_we = 1'b1; d_size = sz; d_addr = a; d_wdata = wd;
        #1;
        chk("st_c0_stall", 32'(d_stall), 32'd1);
        chk("st_c0_memreq", 32'(mem_req), 32'd0);
        tick;
        mem_gnt = 1'b1;
        #1;
        chk("st_c1_memreq", 32'(mem_req), 32'd1);
        chk("st_c1_we", 32'(mem_we), 32'd1);
        chk("st_c1_addr", mem_addr, ea);
        chk("st_c1_wstrb", 32'(mem_wstrb), 32'(es));
        chk("st_c1_wdata", mem_wdata, ew);
        chk("st_c1_stall", 32'(d_stall), 32'd1);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        #1;
        chk("st_c2_memreq", 32'(mem_req), 32'd0);
        chk("st_c2_rvalid", 32'(d_rvalid), 32'd1);
        chk("st_c2_err", 32'(d_err), 32'd0);
        chk("st_c2_stall", 32'(d_stall), 32'd0);
        tick;
        mem_rvalid = 1'b0; d_req = 1'b0;
        #1;
        chk("st_c3_rvalid", 32'(d_rvalid), 32'd0);
        $display("txn store size=%0d addr=%h wdata=%h", sz, a, wd);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        tick; tick;
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_memwe", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_drvalid", 32'(d_rvalid), 32'd0);
        chk("rst_irvalid", 32'(i_rvalid), 32'd0);
        chk("rst_derr", 32'(d_err), 32'd0);
        $display("txn reset");
        rst_n = 1'b1;

        // Strobe generation: word, byte, half
        store_imm(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        store_imm(2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5);
        store_imm(2'b01, 32'h0000_0202, 32'h0000_1234, 32'h0000_0200, 4'b1100, 32'h1234_1234);
        store_imm(2'b00, 32'h0000_0210, 32'h0000_003C, 32'h0000_0210, 4'b0001, 32'h3C3C_3C3C);

        // Simultaneous I and D: D load first, I after one IDLE cycle
        tick;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h40;
        i_req = 1'b1; i_addr = 32'h80;
        #1;
        chk("sim_c0_istall", 32'(i_stall), 32'd1);
        chk("sim_c0_dstall", 32'(d_stall), 32'd1);
        tick;
        mem_gnt = 1'b1;
        #1;
        chk("sim_c1_memreq", 32'(mem_req), 32'd1);
        chk("sim_c1_we", 32'(mem_we), 32'd0);
        chk("sim_c1_addr", mem_addr, 32'h40);
        chk("sim_c1_wstrb", 32'(mem_wstrb), 32'd0);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        #1;
        chk("sim_c2_drvalid", 32'(d_rvalid), 32'd1);
        chk("sim_c2_drdata", d_rdata, 32'h1122_3344);
        chk("sim_c2_irvalid", 32'(i_rvalid), 32'd0);
        chk("sim_c2_istall", 32'(i_stall), 32'd1);
        $display("txn d load addr=40 rdata=%h", d_rdata);
        tick;
        mem_rvalid = 1'b0; d_req = 1'b0;
        #1;
        chk("sim_c3_memreq_idle", 32'(mem_req), 32'd0);
        chk("sim_c3_istall", 32'(i_stall), 32'd1);
        tick;
        mem_gnt = 1'b1;
        #1;
        chk("sim_c4_memreq", 32'(mem_req), 32'd1);
        chk("sim_c4_addr", mem_addr, 32'h80);
        chk("sim_c4_we", 32'(mem_we), 32'd0);
        chk("sim_c4_istall", 32'(i_stall), 32'd1);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("sim_c5_irvalid", 32'(i_rvalid), 32'd1);
        chk("sim_c5_irdata", i_rdata, 32'hCAFE_F00D);
        chk("sim_c5_drvalid", 32'(d_rvalid), 32'd0);
        chk("sim_c5_istall", 32'(i_stall), 32'd0);
        $display("txn i fetch addr=80 rdata=%h", i_rdata);
        tick;
        mem_rvalid = 1'b0; i_req = 1'b0;
        #1;
        chk("sim_c6_irvalid", 32'(i_rvalid), 32'd0);

        // Delayed grant (3 cycles) and delayed response
        tick;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h300; d_wdata = 32'h55AA_55AA;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("dly_req_held", 32'(mem_req), 32'd1);
            chk("dly_addr_held", mem_addr, 32'h300);
            chk("dly_wdata_held", mem_wdata, 32'h55AA_55AA);
            chk("dly_wstrb_held", 32'(mem_wstrb), 32'hF);
            chk("dly_req_no_rvalid", 32'(d_rvalid), 32'd0);
        end
        tick;
        mem_gnt = 1'b1;
        #1;
        chk("dly_gnt_req", 32'(mem_req), 32'd1);
        chk("dly_gnt_we", 32'(mem_we), 32'd1);
        tick;
        mem_gnt = 1'b0;
        #1;
        chk("dly_resp_memreq", 32'(mem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("dly_resp_drvalid", 32'(d_rvalid), 32'd0);
            chk("dly_resp_irvalid", 32'(i_rvalid), 32'd0);
            chk("dly_resp_dstall", 32'(d_stall), 32'd1);
        end
        tick;
        mem_rvalid = 1'b1;
        #1;
        chk("dly_done_drvalid", 32'(d_rvalid), 32'd1);
        chk("dly_done_irvalid", 32'(i_rvalid), 32'd0);
        tick;
        mem_rvalid = 1'b0; d_req = 1'b0;
        #1;
        chk("dly_after_drvalid", 32'(d_rvalid), 32'd0);
        $display("txn delayed store addr=300");

        // Misaligned word load and illegal size: error pulse, no memory request
        tick;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h102;
        #1;
        chk("err_c0_drvalid", 32'(d_rvalid), 32'd0);
        tick;
        chk("err_c1_drvalid", 32'(d_rvalid), 32'd1);
        chk("err_c1_derr", 32'(d_err), 32'd1);
        chk("err_c1_memreq", 32'(mem_req), 32'd0);
        chk("err_c1_dstall", 32'(d_stall), 32'd0);
        tick;
        d_req = 1'b0;
        #1;
        chk("err_c2_drvalid", 32'(d_rvalid), 32'd0);
        chk("err_c2_derr", 32'(d_err), 32'd0);
        chk("err_c2_memreq", 32'(mem_req), 32'd0);
        $display("txn misaligned word load addr=102");
        tick;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b11; d_addr = 32'h100;
        tick;
        chk("ill_c1_drvalid", 32'(d_rvalid), 32'd1);
        chk("ill_c1_derr", 32'(d_err), 32'd1);
        chk("ill_c1_memreq", 32'(mem_req), 32'd0);
        tick;
        d_req = 1'b0;
        #1;
        chk("ill_c2_derr", 32'(d_err), 32'd0);
        chk("ill_c2_memreq", 32'(mem_req), 32'd0);
        $display("txn illegal size store addr=100");

        // Reset while in RESP; late response is ignored
        tick;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h500;
        tick;
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        rst_n = 1'b0; d_req = 1'b0;
        #1;
        chk("mrst_memreq", 32'(mem_req), 32'd0);
        chk("mrst_addr", mem_addr, 32'd0);
        chk("mrst_drvalid", 32'(d_rvalid), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("late_drvalid", 32'(d_rvalid), 32'd0);
        chk("late_irvalid", 32'(i_rvalid), 32'd0);
        chk("late_memreq", 32'(mem_req), 32'd0);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk("late_after_memreq", 32'(mem_req), 32'd0);
        $display("txn reset mid-transaction");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
